// File: rtl/mem_arbiter.sv
// Byte-serial owner of the RAM/IO port, shared round-robin between instruction fetch and load/store.
// Word fetch ready 5 cycles after grant; stores hold while IO buffer is full; rdy_in low freezes everything.
module mem_arbiter #(
   parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_valid,
   input  logic [31:0] if_addr,
   output logic [31:0] if_result,
   output logic        if_ready,
   input  logic        ls_valid,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic        ls_signed,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ready,
   output logic [31:0] ls_result,
   input  logic        clear
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   logic [1:0]  state;
   logic [2:0]  cnt;
   logic [2:0]  len;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] lanes;
   logic        sgn;
   logic        is_wr;
   logic        owner;
   logic        last_grant;

   logic [31:0] cur_addr;
   logic        stall;
   logic        if_flush;
   logic        if_req;
   logic        grant_ls;
   logic        grant_if;
   logic [2:0]  ls_len;
   logic [7:0]  wr_byte;
   logic [31:0] ext;

   assign cur_addr = addr + {29'd0, cnt};
   assign stall    = (state == S_WRITE) && (cur_addr >= IO_BASE) && io_buffer_full;
   assign if_flush = clear && (owner == OWN_IF) && ((state == S_READ) || (state == S_DONE));

   // A flush in IDLE only blocks the fetcher; the load/store side may still win.
   assign if_req   = if_valid && !clear;
   assign grant_ls = ls_valid && (!if_req || (last_grant == OWN_IF));
   assign grant_if = if_req && !grant_ls;

   always_comb begin
      case (ls_size)
         2'b00:   ls_len = 3'd1;
         2'b01:   ls_len = 3'd2;
         default: ls_len = 3'd4;
      endcase
   end

   always_comb begin
      case (cnt[1:0])
         2'd0:    wr_byte = wdata[7:0];
         2'd1:    wr_byte = wdata[15:8];
         2'd2:    wr_byte = wdata[23:16];
         default: wr_byte = wdata[31:24];
      endcase
   end

   always_comb begin
      case (len)
         3'd1:    ext = {{24{sgn & lanes[7]}}, lanes[7:0]};
         3'd2:    ext = {{16{sgn & lanes[15]}}, lanes[15:0]};
         default: ext = lanes;
      endcase
   end

   // Once every address is issued the bus goes quiet, so no extra IO read happens.
   assign mem_a    = (((state == S_READ) || (state == S_WRITE)) && (cnt < len)) ? cur_addr : 32'd0;
   assign mem_wr   = (state == S_WRITE) && rdy_in && !stall;
   assign mem_dout = (state == S_WRITE) ? wr_byte : 8'd0;

   assign if_ready  = (state == S_DONE) && (owner == OWN_IF) && rdy_in && !clear;
   assign ls_ready  = (state == S_DONE) && (owner == OWN_LS) && rdy_in;
   assign if_result = if_ready ? lanes : 32'd0;
   assign ls_result = (ls_ready && !is_wr) ? ext : 32'd0;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         len        <= 3'd0;
         addr       <= 32'd0;
         wdata      <= 32'd0;
         lanes      <= 32'd0;
         sgn        <= 1'b0;
         is_wr      <= 1'b0;
         owner      <= OWN_IF;
         last_grant <= OWN_IF;
      end else if (rdy_in) begin
         case (state)
            S_IDLE: begin
               cnt   <= 3'd0;
               lanes <= 32'd0;
               if (grant_ls) begin
                  owner      <= OWN_LS;
                  last_grant <= OWN_LS;
                  addr       <= ls_addr;
                  len        <= ls_len;
                  wdata      <= ls_wdata;
                  sgn        <= ls_signed;
                  is_wr      <= ls_wr;
                  state      <= ls_wr ? S_WRITE : S_READ;
               end else if (grant_if) begin
                  owner      <= OWN_IF;
                  last_grant <= OWN_IF;
                  addr       <= if_addr;
                  len        <= 3'd4;
                  wdata      <= 32'd0;
                  sgn        <= 1'b0;
                  is_wr      <= 1'b0;
                  state      <= S_READ;
               end
            end
            S_READ: begin
               if (if_flush) begin
                  state <= S_IDLE;
                  cnt   <= 3'd0;
               end else begin
                  // mem_din now holds the byte addressed one cycle earlier.
                  case (cnt)
                     3'd1:    lanes[7:0]   <= mem_din;
                     3'd2:    lanes[15:8]  <= mem_din;
                     3'd3:    lanes[23:16] <= mem_din;
                     3'd4:    lanes[31:24] <= mem_din;
                     default: ;
                  endcase
                  if (cnt == len) state <= S_DONE;
                  else            cnt   <= cnt + 3'd1;
               end
            end
            S_WRITE: begin
               if (!stall) begin
                  if (cnt == len - 3'd1) state <= S_DONE;
                  else                   cnt   <= cnt + 3'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

   logic        clk_in, rst_in, rdy_in;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;
   logic        if_valid;
   logic [31:0] if_addr, if_result;
   logic        if_ready;
   logic        ls_valid, ls_wr, ls_signed;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata, ls_result;
   logic        ls_ready, clear;

   int checks = 0;
   int failures = 0;

   logic [7:0] ram [0:262143];

   mem_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .if_valid(if_valid), .if_addr(if_addr), .if_result(if_result), .if_ready(if_ready),
      .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_size(ls_size), .ls_signed(ls_signed),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_result(ls_result),
      .clear(clear)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) mem_din <= ram[mem_a[17:0]];

   // Runs one granted LS transaction; cyc counts cycles after the grant edge, -1 on timeout.
   task automatic wait_ls(output int cyc, output logic [31:0] res);
      cyc = -1;
      res = 32'd0;
      @(posedge clk_in);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_in);
         if (ls_ready) begin
            cyc = k;
            res = ls_result;
            break;
         end
      end
      ls_valid = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic wait_if(output int cyc, output logic [31:0] res);
      cyc = -1;
      res = 32'd0;
      @(posedge clk_in);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_in);
         if (if_ready) begin
            cyc = k;
            res = if_result;
            break;
         end
      end
      if_valid = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic start_ls(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
      ls_wr = wr; ls_size = sz; ls_signed = sg; ls_addr = a; ls_wdata = d;
      ls_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
      if_valid = 1'b0; if_addr = 32'd0;
      ls_valid = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
      ls_addr = 32'd0; ls_wdata = 32'd0;
      #12;
      checks++;
      if (mem_a !== 32'd0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
      checks++;
      if ({mem_wr, mem_dout} !== 9'd0) begin failures++; $display("FAIL reset_mem_wr_dout got=%b/%h exp=0/00", mem_wr, mem_dout); end
      checks++;
      if ({if_ready, ls_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", if_ready, ls_ready); end
      checks++;
      if ({if_result, ls_result} !== 64'd0) begin failures++; $display("FAIL reset_results got=%h/%h exp=0/0", if_result, ls_result); end
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic test_fetch;
      ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
      if_addr = 32'h100; if_valid = 1'b1;
      @(posedge clk_in);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_in);
         if (k < 4) begin
            checks++;
            if (mem_a !== 32'h100 + k || mem_wr !== 1'b0) begin
               failures++; $display("FAIL fetch_addr cyc=%0d got=%h/%b exp=%h/0", k, mem_a, mem_wr, 32'h100 + k);
            end
         end
         checks++;
         if (if_ready !== (k == 5)) begin failures++; $display("FAIL fetch_ready cyc=%0d got=%b exp=%b", k, if_ready, k == 5); end
         if (k == 5) begin
            checks++;
            if (if_result !== 32'h0000_0513) begin failures++; $display("FAIL fetch_result got=%h exp=00000513", if_result); end
         end
      end
      if_valid = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_loads;
      int c;
      logic [31:0] r;
      ram[18'h20] = 8'h80; ram[18'h21] = 8'h34; ram[18'h22] = 8'h92;
      ram[18'h3FFFF] = 8'h11; ram[18'h0] = 8'h22; ram[18'h1] = 8'h33; ram[18'h2] = 8'h44;
      start_ls(1'b0, 2'b00, 1'b1, 32'h20, 32'd0);
      wait_ls(c, r);
      checks++;
      if (c !== 2 || r !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed got=%0d/%h exp=2/ffffff80", c, r); end
      start_ls(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
      wait_ls(c, r);
      checks++;
      if (c !== 2 || r !== 32'h0000_0080) begin failures++; $display("FAIL lb_unsigned got=%0d/%h exp=2/00000080", c, r); end
      start_ls(1'b0, 2'b01, 1'b1, 32'h21, 32'd0);
      wait_ls(c, r);
      checks++;
      if (c !== 3 || r !== 32'hFFFF_9234) begin failures++; $display("FAIL lh_unaligned got=%0d/%h exp=3/ffff9234", c, r); end
      start_ls(1'b0, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'd0);
      wait_ls(c, r);
      checks++;
      if (c !== 5 || r !== 32'h4433_2211) begin failures++; $display("FAIL lw_wrap got=%0d/%h exp=5/44332211", c, r); end
   endtask

   task automatic test_arbitration;
      int n = 0;
      int cyc [3];
      logic who [3];
      logic [31:0] res [3];
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      if_addr = 32'h100; if_valid = 1'b1;
      start_ls(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
      @(posedge clk_in);
      for (int k = 0; k < 30 && n < 3; k++) begin
         @(negedge clk_in);
         if (ls_ready)      begin who[n] = 1'b1; cyc[n] = k; res[n] = ls_result; n++; end
         else if (if_ready) begin who[n] = 1'b0; cyc[n] = k; res[n] = if_result; n++; end
      end
      if_valid = 1'b0; ls_valid = 1'b0;
      @(negedge clk_in);
      checks++;
      if (n !== 3) begin failures++; $display("FAIL arb_count got=%0d exp=3", n); end
      else begin
         checks++;
         if (who[0] !== 1'b1 || cyc[0] !== 2 || res[0] !== 32'h80) begin
            failures++; $display("FAIL arb_first got=%b/%0d/%h exp=1/2/00000080", who[0], cyc[0], res[0]);
         end
         checks++;
         if (who[1] !== 1'b0 || cyc[1] !== 9 || res[1] !== 32'h513) begin
            failures++; $display("FAIL arb_second got=%b/%0d/%h exp=0/9/00000513", who[1], cyc[1], res[1]);
         end
         checks++;
         if (who[2] !== 1'b1 || cyc[2] !== 13) begin
            failures++; $display("FAIL arb_third got=%b/%0d exp=1/13", who[2], cyc[2]);
         end
      end
   endtask

   task automatic test_io_store;
      logic [31:0] d = 32'hDDCC_BBAA;
      logic exp_wr;
      int idx;
      start_ls(1'b1, 2'b10, 1'b0, 32'h0003_0000, d);
      @(posedge clk_in);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_in);
         io_buffer_full = (k >= 1 && k <= 3);
         #1;
         exp_wr = (k == 0) || (k >= 4 && k <= 6);
         idx = (k == 0) ? 0 : k - 3;
         checks++;
         if (mem_wr !== exp_wr) begin failures++; $display("FAIL io_wr cyc=%0d got=%b exp=%b", k, mem_wr, exp_wr); end
         if (exp_wr) begin
            checks++;
            if (mem_a !== 32'h0003_0000 + idx || mem_dout !== 8'(d >> (8 * idx))) begin
               failures++; $display("FAIL io_byte cyc=%0d got=%h/%h exp=%h/%h", k, mem_a, mem_dout,
                                    32'h0003_0000 + idx, 8'(d >> (8 * idx)));
            end
         end
         checks++;
         if (ls_ready !== (k == 7)) begin failures++; $display("FAIL io_ready cyc=%0d got=%b exp=%b", k, ls_ready, k == 7); end
         if (k == 7) begin
            checks++;
            if (ls_result !== 32'd0) begin failures++; $display("FAIL store_result got=%h exp=0", ls_result); end
         end
      end
      ls_valid = 1'b0;
      @(negedge clk_in);
      // RAM space ignores a full IO buffer.
      io_buffer_full = 1'b1;
      start_ls(1'b1, 2'b01, 1'b0, 32'h40, 32'h0000_5A6B);
      @(posedge clk_in);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         checks++;
         if (k < 2 && (mem_wr !== 1'b1 || mem_a !== 32'h40 + k || mem_dout !== ((k == 0) ? 8'h6B : 8'h5A))) begin
            failures++; $display("FAIL ram_store cyc=%0d got=%b/%h/%h", k, mem_wr, mem_a, mem_dout);
         end else if (k == 2 && (ls_ready !== 1'b1 || mem_wr !== 1'b0)) begin
            failures++; $display("FAIL ram_store_ready got=%b/%b exp=1/0", ls_ready, mem_wr);
         end
      end
      ls_valid = 1'b0; io_buffer_full = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_clear;
      int c;
      logic [31:0] r;
      if_addr = 32'h200; if_valid = 1'b1;
      @(posedge clk_in);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         clear = (k == 2);
         checks++;
         if (if_ready !== 1'b0) begin failures++; $display("FAIL clear_no_ready cyc=%0d got=%b exp=0", k, if_ready); end
         if (k == 3) begin
            checks++;
            if (mem_a !== 32'd0) begin failures++; $display("FAIL clear_idle got=%h exp=0", mem_a); end
            if_addr = 32'h100;
         end
      end
      @(posedge clk_in);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk_in);
         if (j == 0) begin
            checks++;
            if (mem_a !== 32'h100) begin failures++; $display("FAIL clear_regrant got=%h exp=00000100", mem_a); end
         end
         checks++;
         if (if_ready !== (j == 5)) begin failures++; $display("FAIL clear_refetch cyc=%0d got=%b exp=%b", j + 4, if_ready, j == 5); end
      end
      if_valid = 1'b0;
      @(negedge clk_in);
      // Flush held in IDLE and through an LS load: fetch blocked, load completes.
      clear = 1'b1; if_valid = 1'b1; if_addr = 32'h100;
      start_ls(1'b0, 2'b00, 1'b1, 32'h20, 32'd0);
      @(posedge clk_in);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         if (k == 0) begin
            checks++;
            if (mem_a !== 32'h20) begin failures++; $display("FAIL clear_ls_grant got=%h exp=00000020", mem_a); end
         end
      end
      checks++;
      if (ls_ready !== 1'b1 || ls_result !== 32'hFFFF_FF80) begin
         failures++; $display("FAIL clear_ls_kept got=%b/%h exp=1/ffffff80", ls_ready, ls_result);
      end
      ls_valid = 1'b0; clear = 1'b0;
      @(negedge clk_in);
      wait_if(c, r);
      checks++;
      if (c !== 5 || r !== 32'h513) begin failures++; $display("FAIL clear_if_after got=%0d/%h exp=5/00000513", c, r); end
   endtask

   task automatic test_pause;
      logic exp_wr;
      start_ls(1'b1, 2'b01, 1'b0, 32'h60, 32'h0000_1234);
      @(posedge clk_in);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         rdy_in = (k != 1);
         #1;
         exp_wr = (k == 0) || (k == 2);
         checks++;
         if (mem_wr !== exp_wr || ls_ready !== (k == 3)) begin
            failures++; $display("FAIL pause cyc=%0d got=%b/%b exp=%b/%b", k, mem_wr, ls_ready, exp_wr, k == 3);
         end
         if (k == 2) begin
            checks++;
            if (mem_a !== 32'h61 || mem_dout !== 8'h12) begin failures++; $display("FAIL pause_byte got=%h/%h exp=00000061/12", mem_a, mem_dout); end
         end
      end
      rdy_in = 1'b1; ls_valid = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_reset_mid_write;
      int c;
      logic [31:0] r;
      start_ls(1'b1, 2'b10, 1'b0, 32'h50, 32'hAABB_CCDD);
      @(posedge clk_in);
      @(negedge clk_in);
      @(negedge clk_in);
      checks++;
      if (mem_wr !== 1'b1 || mem_dout !== 8'hCC) begin failures++; $display("FAIL pre_reset_write got=%b/%h exp=1/cc", mem_wr, mem_dout); end
      #2 rst_in = 1'b1;
      #1;
      checks++;
      if ({mem_wr, ls_ready, if_ready} !== 3'b000 || mem_a !== 32'd0) begin
         failures++; $display("FAIL async_reset got=%b%b%b/%h exp=000/0", mem_wr, ls_ready, if_ready, mem_a);
      end
      ls_valid = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b0;
      start_ls(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
      wait_ls(c, r);
      checks++;
      if (c !== 2 || r !== 32'h80) begin failures++; $display("FAIL post_reset_load got=%0d/%h exp=2/00000080", c, r); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_loads();
      test_arbitration();
      test_io_store();
      test_clear();
      test_pause();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single owner of the byte-wide RAM/IO port.
- Shares the port between the instruction fetcher (word reads) and the load/store buffer (byte/half/word loads and stores).
- Serialises each request into consecutive little-endian byte accesses and returns one assembled result with a single-cycle ready pulse.
- Honours ROB flush for fetches and IO back-pressure for stores.

Parameters:
IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO space; writes there obey io_buffer_full

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global pause; low freezes all state
mem_din  in  8  RAM read byte, valid the cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write, 0 = read
io_buffer_full  in  1  IO write buffer full
if_valid  in  1  fetch request, held until if_ready
if_addr  in  32  fetch address
if_result  out  32  fetched word
if_ready  out  1  one-cycle fetch done pulse
ls_valid  in  1  load/store request, held until ls_ready
ls_wr  in  1  1 = store
ls_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
ls_signed  in  1  sign-extend load result
ls_addr  in  32  byte address (no alignment requirement)
ls_wdata  in  32  store data, low n bytes used
ls_ready  out  1  one-cycle load/store done pulse
ls_result  out  32  extended load data; 0 for stores
clear  in  1  ROB flush

Behaviour:
- Reset (asynchronous, active-high): state IDLE, byte counter 0, last_grant = IF; all outputs 0.
- States:
  - IDLE: mem_a = 0, mem_wr = 0.
  - READ, WRITE: active transfer.
  - DONE: exactly one cycle; raises the owner's ready. No request is accepted in DONE.
- Arbitration at an IDLE edge:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant (round robin); update last_grant.
  - Latch addr, n (4 for IF; 1/2/4 for LS), write data, signedness and owner.
  - Next state: READ, or WRITE when an LS store.
- Byte counter i runs 0..n-1. mem_a = addr + i, 32-bit wrap.
- Read timing, cycle 0 = first cycle after grant edge:
  - Address i is driven in cycle i.
  - mem_din is captured into byte lane i at the end of cycle i+1.
  - After lane n-1 is captured: DONE in cycle n+1, so a word read is ready in cycle 5.
- Write timing:
  - Byte i is driven in cycle i with mem_wr = 1 and mem_dout = wdata[8i+7:8i].
  - DONE follows in cycle n.
- IO stall: in WRITE, if mem_a >= IO_BASE and io_buffer_full = 1:
  - mem_wr = 0 that cycle; counter holds.
  - The byte retries the next cycle.
- Results:
  - if_result = assembled word.
  - ls_result = bytes sign- or zero-extended from width 8n; 0 after a store.
  - Results are valid only while ready is high.
- clear at an edge:
  - Owner IF in READ or DONE: go to IDLE, no if_ready pulse (a suppressed DONE does not pulse).
  - In IDLE: IF is not granted at that edge; LS may be.
  - LS transactions are never aborted by clear.
- rdy_in = 0: state, counter and lanes are frozen; mem_wr is forced 0; the cycle does not count.
- Requesters must hold valid/addr stable until ready.
- Valid still high in the DONE cycle is not re-granted. A new request is accepted at the first IDLE edge.

Test Plan:
- Fetch only: if_addr = 0x100, RAM[0x100..0x103] = 13,05,00,00 -> mem_a 0x100..0x103 in cycles 0-3; if_ready in cycle 5 only; if_result = 0x00000513.
- Signed byte load: ls_size = 00, ls_signed = 1, RAM[0x20] = 0x80 -> ls_result = 0xFFFFFF80, ls_ready in cycle 2. Same with ls_signed = 0 -> 0x00000080.
- Simultaneous requests from reset -> LS granted first; IF granted next. With both held continuously, grants alternate LS, IF, LS.
- Word store to 0x30000 with io_buffer_full high for 3 cycles starting cycle 1 -> byte 0 written in cycle 0; mem_wr low in cycles 1-3; bytes 1-3 written in cycles 4-6; ls_ready in cycle 7.
- clear asserted in cycle 2 of a fetch -> IDLE next cycle, no if_ready. A new if_addr is granted at the next edge, unless LS wins round robin.
- rst_in asserted mid-WRITE (asynchronous, between edges) -> mem_wr and all ready outputs 0 immediately; state IDLE when reset releases.
